sort4_loader: RTL
=================

# sort4_loader

Upstream feeder for the `sort4` combinational sorter. It accepts a serial stream of unsigned words, one per handshake, and packs every four consecutive words into a registered group `a`, `b`, `c`, `d`. The group is presented to `sort4` together with a valid/ready handshake so the downstream capture stage can take the sorted result. Words arrive in order: first word to `a`, fourth word to `d`. The input may stall independently of the output.

## Interface
- `W`, 4, data word width; must match `sort4` port width
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `clr`  in  1  synchronous clear; discards the partially assembled group
- `in_data`  in  W  input word
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader can accept a word this cycle
- `a`, `b`, `c`, `d`  out  W each  registered group, wired to `sort4` inputs
- `out_valid`  out  1  `a`..`d` hold a complete group
- `out_ready`  in  1  downstream takes the group this cycle
- `grp_cnt`  out  8  completed groups delivered (out handshakes), wraps 255->0

## Operation
- Accept: an input word is taken when `in_valid && in_ready`. An output group is delivered when `out_valid && out_ready`.
- Assembly: assembly registers `s0`, `s1`, `s2` plus 2-bit `fill` (0..3) counting the words held.
- Words 1 to 3 go to `s[fill]` and then increment `fill`. No output change.
- Word 4 (accepted while `fill==3`):
  - `{a,b,c,d} <= {s0,s1,s2,in_data}`
  - `out_valid <= 1`
  - `fill <= 0`
- `in_ready = (fill != 3) || !out_valid || out_ready`. The loader stalls only when word 4 would overwrite a held, unconsumed group.
- Output handshake without a new group: `out_valid <= 0`. A new group loaded in the same cycle wins, so `out_valid` stays 1 and `a`..`d` update. This gives back-to-back groups with no bubble.
- `a`..`d` hold their value while `out_valid && !out_ready`. They also hold after consumption; their value is don't-care but must not glitch.
- `grp_cnt` increments on every output handshake and wraps modulo 256.
- `clr`:
  - Sets `fill <= 0` and takes priority over an input accept in the same cycle; the word is dropped, and `in_ready` is still driven by the formula.
  - Does not touch `out_valid`, `a`..`d` or `grp_cnt`. A held group is still delivered.
- States (implied by `fill` and `out_valid`): EMPTY(0,0), PARTIAL(1..3,0), HELD(0..3,1), STALL(3,1 with `!out_ready`).

## Timing
- Reset (async, while `rst_n` low): `fill=0`, `s0`..`s2=0`, `a`..`d=0`, `out_valid=0`, `grp_cnt=0`. `in_ready` reads 1 during and after reset.
- Reset mid-group or mid-hold: everything is discarded immediately, with no partial delivery after release.
- Latency: `out_valid` rises on the clock edge that accepts word 4. The group is visible the next cycle; the `sort4` result is valid in the same cycle as `out_valid`.
- Throughput: 1 word/cycle sustained with `out_ready=1`, i.e. one group every 4 cycles.
- `in_ready` is combinational from `fill`, `out_valid` and `out_ready` only, never from `in_valid`. `out_valid` is fully registered.
- No combinational path from `in_data` to any output.

## Test plan
- Reset then single group: after reset release, send 3,9,1,7 with `out_ready=1` -> `out_valid` high 1 cycle with a=3, b=9, c=1, d=7; sort4 gives ra..rd sorted; `grp_cnt=1`.
- Streaming: 12 words 0..11 continuous, `in_valid=1`, `out_ready=1` -> groups {0,1,2,3}, {4,5,6,7}, {8,9,10,11}; `in_ready` never low; `grp_cnt=3`.
- Backpressure: `out_ready=0`, send 8 words 1..8 ->
  - group {1,2,3,4} held
  - `in_ready` drops after words 5,6,7 are taken (`fill=3`)
  - raise `out_ready` -> {1,2,3,4} delivered; word 8 accepted that cycle; {5,6,7,8} valid next cycle with no bubble
- Clear: send 5,6 then pulse `clr` together with word 7, then send 10,11,12,13 -> word 7 dropped; the only group is {10,11,12,13}.
- Async reset mid-hold: group {2,4,6,8} held with `out_ready=0`; assert `rst_n=0` between edges -> `out_valid`, `a`..`d`, `grp_cnt` go to 0 immediately; no delivery after release.
- Wrap: deliver 256 groups -> `grp_cnt` returns to 0; group 257 gives `grp_cnt=1`.

Source files
------------

// File: rtl/sort4_loader.sv
// Serial-to-parallel feeder for sort4: packs four accepted words into a
// registered group a..d and offers it downstream over a valid/ready handshake.
module sort4_loader #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   grp_cnt
);

  // Operating states are implied by fill and out_valid:
  // state   | meaning
  // EMPTY   | fill=0, out_valid=0
  // PARTIAL | fill=1..3, out_valid=0
  // HELD    | out_valid=1, group waiting for downstream
  // STALL   | fill=3, out_valid=1, out_ready=0 -> input blocked
  localparam logic [1:0] FILL_LAST = 2'd3;

  logic [W-1:0] s0, s1, s2;
  logic [1:0]   fill;
  logic         take;
  logic         load;
  logic         deliver;

  // Only the fourth word can collide with a held group, so only it stalls.
  assign in_ready = (fill != FILL_LAST) || !out_valid || out_ready;
  assign take     = in_valid && in_ready && !clr;
  assign load     = take && (fill == FILL_LAST);
  assign deliver  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= 2'd0;
      s0   <= '0;
      s1   <= '0;
      s2   <= '0;
    end else if (clr) begin
      fill <= 2'd0;
    end else if (take) begin
      case (fill)
        2'd0:    s0 <= in_data;
        2'd1:    s1 <= in_data;
        2'd2:    s2 <= in_data;
        default: ;
      endcase
      fill <= fill + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      c <= '0;
      d <= '0;
    end else if (load) begin
      a <= s0;
      b <= s1;
      c <= s2;
      d <= in_data;
    end
  end

  // A new group loaded in the delivery cycle keeps out_valid high (no bubble).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (deliver) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_cnt <= 8'd0;
    end else if (deliver) begin
      grp_cnt <= grp_cnt + 8'd1;
    end
  end

endmodule
